mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum cycles one grant is held; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  8  request lines; bit i = requester i wants the shared 8:1 mux.
REQ-005 gnt  output 8  registered one-hot grant; all-zero when no grant.
REQ-006 sel  output 3  registered binary index of granted requester; drives the 8:1 mux select.
REQ-007 busy output 1  registered; high while a grant is active.

Function
REQ-008 The FSM SHALL have exactly two states: IDLE, GRANT.
REQ-009 Internal state SHALL be: round-robin pointer ptr (3 bits), hold counter cnt (8 bits), FSM state.
REQ-010 Pick rule SHALL be: first asserted bit of (req & ~mask), searching ptr, ptr+1, ..., ptr+7 modulo 8.
REQ-011 In IDLE with req == 0, outputs SHALL stay gnt=0, sel=0, busy=0.
REQ-012 In IDLE with req != 0, pick with mask=0; next edge: gnt=1<<k, sel=k, busy=1, cnt=0, state GRANT (1-cycle latency req->gnt).
REQ-013 In GRANT, cnt SHALL increment by 1 each cycle while the grant is held.
REQ-014 The grant SHALL release on the edge where req[sel]==0 or cnt==MAX_HOLD-1, whichever comes first.
REQ-015 On release, ptr SHALL become (sel+1) mod 8; index 7 wraps to 0.
REQ-016 On release, re-pick SHALL use the new ptr and mask = current gnt, so the releasing requester is excluded for this pick.
REQ-017 If the re-pick finds a requester, the new grant SHALL load on the same release edge (no idle bubble) with cnt=0.
REQ-018 If the re-pick finds none, state SHALL go IDLE with gnt=0, sel=0, busy=0.
REQ-019 A timed-out requester still asserting with no other requester SHALL see exactly one IDLE cycle, then be re-granted.
REQ-020 Requests arriving or changing during GRANT SHALL NOT alter gnt/sel before release.
REQ-021 When busy=1, gnt SHALL equal 1<<sel; gnt SHALL never have more than one bit set.
REQ-022 ptr SHALL change only on release edges, never on a grant from IDLE.

Reset
REQ-023 rst high SHALL immediately and asynchronously force gnt=0, sel=0, busy=0, ptr=0, cnt=0, state IDLE, including mid-grant.
REQ-024 After rst deasserts, the first pick SHALL occur at the first clk edge with req != 0, using ptr=0.

Structure
REQ-025 Shared package mux_arb_pkg SHALL hold N_REQ=8, SEL_W=3, CNT_W=8 and the IDLE/GRANT state encoding.
REQ-026 The pick logic SHALL be one combinational sub-module, mux_arb_rr_pick.
REQ-027 mux_arb_rr_pick inputs: req, mask, ptr; outputs: found, idx.

Verification
REQ-028 Reset then req=8'h00 for 10 cycles -> gnt=0, sel=0, busy=0 throughout.
REQ-029 req=8'h24 from IDLE, ptr=0 -> next cycle sel=2, gnt=8'h04.
REQ-030 Requester 2 drops, req=8'h20 -> same edge sel=5, gnt=8'h20, ptr=3.
REQ-031 req=8'hFF held, MAX_HOLD=16 -> grants 0,1,...,7,0 in order, each exactly 16 cycles, no gaps.
REQ-032 Only req[7] held, MAX_HOLD=4 -> sel=7 for 4 cycles, 1 idle cycle, ptr=0, sel=7 re-granted.
REQ-033 rst pulsed mid-grant of requester 3, between clk edges -> gnt=0 and busy=0 before next edge; ptr=0 afterward.
REQ-034 req=8'h81 with ptr=7 -> requester 7 granted first; after its release, requester 0 granted with no bubble.
REQ-035 All scenarios -> gnt==1<<sel whenever busy=1, checked by an assertion every cycle.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared widths, state encoding and helpers for the round-robin mux-select arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Converts a binary requester index into its one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~mask) starting at ptr, wrapping modulo N_REQ.
module mux_arb_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0]   cand;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;

  // Rotate candidates so that bit 0 corresponds to ptr, then take the lowest set bit.
  always_comb begin
    cand    = req & ~mask;
    doubled = {cand, cand} >> ptr;
    rotated = doubled[N_REQ-1:0];
    found   = |rotated;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        idx = ptr + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux, with a bounded hold time per grant.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [SEL_W-1:0] sel_n;
  logic             busy_n;

  logic             release_grant;
  logic [SEL_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  // During a grant the picker already looks ahead from sel+1 with the current holder masked out.
  mux_arb_rr_pick u_pick (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    release_grant = (state == GRANT) && (!req[sel] || (cnt == HOLD_LAST));
    pick_ptr      = (state == GRANT) ? sel + SEL_W'(1) : ptr;
    pick_mask     = (state == GRANT) ? gnt : '0;
    state_n       = state;
    case (state)
      IDLE:    if (pick_found) state_n = GRANT;
      GRANT:   if (release_grant && !pick_found) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next registered outputs; ptr only moves on a release so grants from IDLE keep it.
  always_comb begin
    gnt_n  = gnt;
    sel_n  = sel;
    busy_n = busy;
    cnt_n  = cnt;
    ptr_n  = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_n  = idx_to_onehot(pick_idx);
          sel_n  = pick_idx;
          busy_n = 1'b1;
          cnt_n  = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          ptr_n = sel + SEL_W'(1);
          cnt_n = '0;
          if (pick_found) begin
            gnt_n  = idx_to_onehot(pick_idx);
            sel_n  = pick_idx;
            busy_n = 1'b1;
          end else begin
            gnt_n  = '0;
            sel_n  = '0;
            busy_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        gnt_n  = '0;
        sel_n  = '0;
        busy_n = 1'b0;
        cnt_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed, table-driven bench for mux_sel_arbiter; two instances cover MAX_HOLD of 16 and 4.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic [2:0] ptr;
  } vec_t;

  vec_t vecs[11];

  mux_sel_arbiter #(.MAX_HOLD(16)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .sel(sel_a), .busy(busy_a)
  );

  mux_sel_arbiter #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .sel(sel_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_a(input string name, input logic [7:0] g, input logic [2:0] s, input logic b);
    check_output(name, {20'd0, gnt_a, sel_a, busy_a}, {20'd0, g, s, b});
  endtask

  task automatic check_b(input string name, input logic [7:0] g, input logic [2:0] s, input logic b);
    check_output(name, {20'd0, gnt_b, sel_b, busy_b}, {20'd0, g, s, b});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Grant must be one-hot and match sel while busy, on both instances every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(busy_a && (gnt_a !== (8'h01 << sel_a))) && $onehot0(gnt_a)
              && !(busy_b && (gnt_b !== (8'h01 << sel_b))) && $onehot0(gnt_b))
      else begin
        failures++;
        $display("[TB] FAIL onehot_sel: a gnt=0x%0h sel=%0d busy=%0b, b gnt=0x%0h sel=%0d busy=%0b",
                 gnt_a, sel_a, busy_a, gnt_b, sel_b, busy_b);
      end
    end
  end

  initial begin
    //             req     gnt     sel   busy  ptr
    vecs[0]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
    vecs[1]  = '{8'h24, 8'h04, 3'd2, 1'b1, 3'd0};
    vecs[2]  = '{8'h20, 8'h20, 3'd5, 1'b1, 3'd3};
    vecs[3]  = '{8'h20, 8'h20, 3'd5, 1'b1, 3'd3};
    vecs[4]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd6};
    vecs[5]  = '{8'h40, 8'h40, 3'd6, 1'b1, 3'd6};
    vecs[6]  = '{8'h81, 8'h80, 3'd7, 1'b1, 3'd7};
    vecs[7]  = '{8'hFF, 8'h80, 3'd7, 1'b1, 3'd7};
    vecs[8]  = '{8'h01, 8'h01, 3'd0, 1'b1, 3'd0};
    vecs[9]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd1};
    vecs[10] = '{8'h10, 8'h10, 3'd4, 1'b1, 3'd1};

    rst   = 1'b1;
    req_a = 8'h00;
    req_b = 8'h00;
    tick();
    tick();
    check_a("reset_a", 8'h00, 3'd0, 1'b0);
    check_b("reset_b", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check_a("idle_a", 8'h00, 3'd0, 1'b0);
      check_b("idle_b", 8'h00, 3'd0, 1'b0);
    end

    for (int i = 0; i < 11; i++) begin
      req_a = vecs[i].req;
      tick();
      check_a($sformatf("vec%0d_out", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy);
      check_output($sformatf("vec%0d_ptr", i), {29'd0, dut_a.ptr}, {29'd0, vecs[i].ptr});
    end

    // All requesters held: 0..7 then 0 again, each exactly 16 cycles back to back.
    req_a = 8'h00;
    apply_reset();
    req_a = 8'hFF;
    tick();
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 16; c++) begin
        check_a($sformatf("rr_g%0d_c%0d", g, c), 8'h01 << (g % 8), 3'(g % 8), 1'b1);
        tick();
      end
    end

    // Lone requester 7 on the MAX_HOLD=4 instance: timeout, one idle cycle, re-grant.
    req_a = 8'h00;
    apply_reset();
    req_b = 8'h80;
    tick();
    for (int c = 0; c < 4; c++) begin
      check_b($sformatf("to_hold_c%0d", c), 8'h80, 3'd7, 1'b1);
      tick();
    end
    check_b("to_idle", 8'h00, 3'd0, 1'b0);
    check_output("to_ptr", {29'd0, dut_b.ptr}, 32'd0);
    tick();
    check_b("to_regrant", 8'h80, 3'd7, 1'b1);
    req_b = 8'h00;
    tick();

    // Asynchronous reset in the middle of requester 3's grant.
    req_a = 8'h04;
    tick();
    check_a("pre_rst_g2", 8'h04, 3'd2, 1'b1);
    req_a = 8'h08;
    tick();
    check_a("pre_rst_g3", 8'h08, 3'd3, 1'b1);
    check_output("pre_rst_ptr", {29'd0, dut_a.ptr}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_a("async_rst", 8'h00, 3'd0, 1'b0);
    #2;
    rst   = 1'b0;
    req_a = 8'h0C;
    #1;
    check_output("post_rst_ptr", {29'd0, dut_a.ptr}, 32'd0);
    check_output("post_rst_cnt", {24'd0, dut_a.cnt}, 32'd0);
    tick();
    check_a("post_rst_pick", 8'h04, 3'd2, 1'b1);
    req_a = 8'h00;
    tick();
    check_a("final_idle", 8'h00, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
